// File: rtl/battle_pkg.sv
// Shared types and screen geometry for the battle game sprite path.
// Direction encoding is common to tank and missile.
package battle_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLYING  = 2'd1,
    EXPLODE = 2'd2
  } missile_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/missile_next_pos.sv
// Steps a square sprite by a signed amount along a direction and
// flags when the stepped square is no longer fully on screen.
module missile_next_pos
  import battle_pkg::*;
#(
  parameter int MISSILE_SIZE = 8
) (
  input  logic signed [11:0] posX,
  input  logic signed [11:0] posY,
  input  dir_t               dir,
  input  logic signed [11:0] step,
  output logic [10:0]        nextX,
  output logic [10:0]        nextY,
  output logic               oob
);

  logic signed [11:0] nx;
  logic signed [11:0] ny;
  int xi;
  int yi;

  // move the position one step along the direction
  always_comb begin
    nx = posX;
    ny = posY;
    unique case (dir)
      UP:    ny = posY - step;
      RIGHT: nx = posX + step;
      DOWN:  ny = posY + step;
      LEFT:  nx = posX - step;
    endcase
  end

  // whole square must stay on screen; negative wraps show as < 0
  always_comb begin
    xi  = int'(nx);
    yi  = int'(ny);
    oob = (xi < 0) || (yi < 0)
       || (xi + MISSILE_SIZE > SCREEN_W)
       || (yi + MISSILE_SIZE > SCREEN_H);
  end

  assign nextX = nx[10:0];
  assign nextY = ny[10:0];

endmodule

// File: rtl/missile_move_controller.sv
// Missile movement stage: spawn at tank muzzle, fly once per frame,
// exit on screen edge, explode on collision, then rearm.
module missile_move_controller
  import battle_pkg::*;
#(
  parameter int SPEED          = 4,
  parameter int MISSILE_SIZE   = 8,
  parameter int TANK_SIZE      = 32,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fire,
  input  logic [10:0] tankTopLeftX,
  input  logic [10:0] tankTopLeftY,
  input  logic [1:0]  tankDir,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  dir,
  output logic        active,
  output logic        exploding,
  output logic        fireAck
);

  localparam logic signed [11:0] CO = 12'((TANK_SIZE - MISSILE_SIZE) / 2);
  localparam logic signed [11:0] TS = 12'(TANK_SIZE);
  localparam logic signed [11:0] MS = 12'(MISSILE_SIZE);
  localparam logic signed [11:0] SP = 12'(SPEED);
  localparam logic [7:0]         LAST = 8'(EXPLODE_FRAMES - 1);

  missile_state_t state, state_n;
  logic [10:0] x_n, y_n;
  logic [1:0]  dir_n;
  logic        active_n, expl_n, ack_n;
  logic        col_flag, flag_n;
  logic [7:0]  cnt, cnt_n;

  logic signed [11:0] tx, ty, sx, sy;
  logic [10:0] sp_x, sp_y, mv_x, mv_y;
  logic        sp_oob, mv_oob;

  assign tx = $signed({1'b0, tankTopLeftX});
  assign ty = $signed({1'b0, tankTopLeftY});

  // muzzle point on the tank edge facing the fire direction
  always_comb begin
    sx = tx;
    sy = ty;
    unique case (dir_t'(tankDir))
      UP:    begin sx = tx + CO; sy = ty - MS; end
      RIGHT: begin sx = tx + TS; sy = ty + CO; end
      DOWN:  begin sx = tx + CO; sy = ty + TS; end
      LEFT:  begin sx = tx - MS; sy = ty + CO; end
    endcase
  end

  missile_next_pos #(.MISSILE_SIZE(MISSILE_SIZE)) u_spawn (
    .posX  (sx),
    .posY  (sy),
    .dir   (dir_t'(tankDir)),
    .step  (12'sd0),
    .nextX (sp_x),
    .nextY (sp_y),
    .oob   (sp_oob)
  );

  missile_next_pos #(.MISSILE_SIZE(MISSILE_SIZE)) u_move (
    .posX  ($signed({1'b0, topLeftX})),
    .posY  ($signed({1'b0, topLeftY})),
    .dir   (dir_t'(dir)),
    .step  (SP),
    .nextX (mv_x),
    .nextY (mv_y),
    .oob   (mv_oob)
  );

  // state and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      topLeftX  <= '0;
      topLeftY  <= '0;
      dir       <= '0;
      active    <= 1'b0;
      exploding <= 1'b0;
      fireAck   <= 1'b0;
      col_flag  <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      topLeftX  <= x_n;
      topLeftY  <= y_n;
      dir       <= dir_n;
      active    <= active_n;
      exploding <= expl_n;
      fireAck   <= ack_n;
      col_flag  <= flag_n;
      cnt       <= cnt_n;
    end
  end

  // next state; collision beats edge exit on the same frame
  always_comb begin
    state_n  = state;
    x_n      = topLeftX;
    y_n      = topLeftY;
    dir_n    = dir;
    active_n = active;
    expl_n   = exploding;
    ack_n    = 1'b0;
    flag_n   = 1'b0;
    cnt_n    = cnt;
    unique case (state)
      IDLE: begin
        if (fire && !sp_oob) begin
          state_n  = FLYING;
          x_n      = sp_x;
          y_n      = sp_y;
          dir_n    = tankDir;
          active_n = 1'b1;
          ack_n    = 1'b1;
        end
      end
      FLYING: begin
        flag_n = col_flag | collision;
        if (startOfFrame) begin
          flag_n = 1'b0;
          if (col_flag || collision) begin
            state_n = EXPLODE;
            expl_n  = 1'b1;
            cnt_n   = '0;
          end else if (mv_oob) begin
            state_n  = IDLE;
            active_n = 1'b0;
          end else begin
            x_n = mv_x;
            y_n = mv_y;
          end
        end
      end
      EXPLODE: begin
        if (startOfFrame) begin
          if (cnt == LAST) begin
            state_n  = IDLE;
            active_n = 1'b0;
            expl_n   = 1'b0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_missile_move_controller.sv
// Directed bench for missile_move_controller.
// Expected outputs are queued at drive time and checked after the edge.
module tb_missile_move_controller;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        fire;
  logic [10:0] tankTopLeftX;
  logic [10:0] tankTopLeftY;
  logic [1:0]  tankDir;
  logic        collision;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic [1:0]  dir;
  logic        active;
  logic        exploding;
  logic        fireAck;

  typedef struct {
    string       tag;
    logic [26:0] v;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  missile_move_controller dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .fire         (fire),
    .tankTopLeftX (tankTopLeftX),
    .tankTopLeftY (tankTopLeftY),
    .tankDir      (tankDir),
    .collision    (collision),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .dir          (dir),
    .active       (active),
    .exploding    (exploding),
    .fireAck      (fireAck)
  );

  task automatic push(input string tag, input int x, input int y,
                      input int d, input bit a, input bit e, input bit f);
    exp_t t;
    t.tag = tag;
    t.v = {11'(x), 11'(y), 2'(d), a, e, f};
    q.push_back(t);
  endtask

  task automatic compare();
    exp_t t;
    logic [26:0] obs;
    obs = {topLeftX, topLeftY, dir, active, exploding, fireAck};
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h required=entry", obs);
    end else begin
      t = q.pop_front();
      assert (obs === t.v) else begin
        miscompares++;
        $error("FAIL %s observed=%h required=%h", t.tag, obs, t.v);
      end
    end
  endtask

  task automatic tank(input int x, input int y, input int d);
    tankTopLeftX = 11'(x);
    tankTopLeftY = 11'(y);
    tankDir      = 2'(d);
  endtask

  task automatic cyc(input bit s, input bit f, input bit c,
                     input int x, input int y, input int d,
                     input bit a, input bit e, input bit k,
                     input string tag);
    startOfFrame = s;
    fire         = f;
    collision    = c;
    push(tag, x, y, d, a, e, k);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset(input string tag);
    startOfFrame = 1'b0;
    fire         = 1'b0;
    collision    = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    push({tag, "_async"}, 0, 0, 0, 0, 0, 0);
    compare();
    @(posedge clk);
    #1;
    push({tag, "_held"}, 0, 0, 0, 0, 0, 0);
    compare();
    resetN = 1'b1;
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    fire         = 1'b1;
    collision    = 1'b0;
    tank(100, 200, 0);
    #13;
    push("t1_rst_fire", 0, 0, 0, 0, 0, 0);
    compare();
    resetN = 1'b1;
    cyc(0, 1, 0, 112, 192, 0, 1, 0, 1, "t1_launch");
    cyc(0, 0, 0, 112, 192, 0, 1, 0, 0, "t1_ack_drop");
    do_reset("t1_rst_fly");

    tank(100, 200, 1);
    cyc(0, 1, 0, 132, 212, 1, 1, 0, 1, "t2_launch");
    cyc(0, 0, 0, 132, 212, 1, 1, 0, 0, "t2_ack_once");

    tank(100, 200, 2);
    cyc(1, 0, 0, 136, 212, 1, 1, 0, 0, "t3_frame1");
    cyc(0, 1, 0, 136, 212, 1, 1, 0, 0, "t3_fire_fly");
    cyc(1, 0, 0, 140, 212, 1, 1, 0, 0, "t3_frame2");
    cyc(1, 0, 0, 144, 212, 1, 1, 0, 0, "t3_frame3");
    do_reset("t3_rst");

    tank(600, 200, 1);
    cyc(0, 1, 0, 632, 212, 1, 1, 0, 1, "t4_spawn_edge");
    cyc(1, 0, 0, 632, 212, 1, 0, 0, 0, "t4_exit_right");
    cyc(0, 0, 0, 632, 212, 1, 0, 0, 0, "t4_idle");
    tank(4, 100, 3);
    cyc(0, 1, 0, 632, 212, 1, 0, 0, 0, "t4_left_reject");
    tank(8, 100, 3);
    cyc(0, 1, 0, 0, 112, 3, 1, 0, 1, "t4_left_spawn");
    cyc(1, 0, 0, 0, 112, 3, 0, 0, 0, "t4_exit_left");
    tank(100, 100, 2);
    cyc(0, 1, 0, 112, 132, 2, 1, 0, 1, "t4_down_spawn");
    cyc(1, 0, 0, 112, 136, 2, 1, 0, 0, "t4_down_move");
    do_reset("t4_rst");

    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, "t5_idle_col");
    tank(100, 200, 1);
    cyc(0, 1, 0, 132, 212, 1, 1, 0, 1, "t5_launch");
    cyc(1, 0, 0, 136, 212, 1, 1, 0, 0, "t5_move");
    cyc(0, 0, 1, 136, 212, 1, 1, 0, 0, "t5_col");
    cyc(0, 0, 0, 136, 212, 1, 1, 0, 0, "t5_sticky");
    cyc(1, 0, 0, 136, 212, 1, 1, 1, 0, "t5_explode");
    for (int i = 0; i < 7; i++)
      cyc(1, 1, 1, 136, 212, 1, 1, 1, 0, "t5_hold");
    cyc(1, 1, 0, 136, 212, 1, 0, 0, 0, "t5_done");
    cyc(0, 1, 0, 132, 212, 1, 1, 0, 1, "t5_autofire");
    do_reset("t5_rst");

    tank(600, 200, 1);
    cyc(0, 1, 0, 632, 212, 1, 1, 0, 1, "t5_edge_launch");
    cyc(0, 0, 1, 632, 212, 1, 1, 0, 0, "t5_edge_col");
    cyc(1, 0, 0, 632, 212, 1, 1, 1, 0, "t5_col_beats_oob");

    do_reset("t6_rst_explode");
    tank(300, 4, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, "t6_reject");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, "t6_reject_held");
    tank(300, 8, 0);
    cyc(0, 1, 0, 312, 0, 0, 1, 0, 1, "t6_top_spawn");
    cyc(1, 0, 0, 312, 0, 0, 0, 0, 0, "t6_exit_top");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
